// File: rtl/morse_pkg.sv
// Shared types and default lengths for the Morse mode controller and its input conditioning.
package morse_pkg;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_t;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    RUN_ENC = 3'd1,
    RUN_DEC = 3'd2,
    DRAIN   = 3'd3,
    FLUSH   = 3'd4
  } ctrl_state_t;

  localparam int DEBOUNCE_DEFAULT = 1000000;
  localparam int FLUSH_DEFAULT    = 4;

  // Map a mode to the state in which its engine runs.
  function automatic ctrl_state_t run_state(input mode_t mode);
    ctrl_state_t st;
    case (mode)
      MODE_ENC: st = RUN_ENC;
      MODE_DEC: st = RUN_DEC;
      default:  st = RUN_ENC;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/morse_mode_ctrl_if.sv
// Engine-side handshake between the mode controller and the encoder/decoder/display.
interface morse_mode_ctrl_if;
  logic enc_busy;
  logic dec_busy;
  logic enc_en;
  logic dec_en;
  logic flush;
  logic state1;
  logic state2;
  logic mode_busy;

  modport master (
    input  enc_busy, dec_busy,
    output enc_en, dec_en, flush, state1, state2, mode_busy
  );

  modport slave (
    output enc_busy, dec_busy,
    input  enc_en, dec_en, flush, state1, state2, mode_busy
  );
endinterface

// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus level debouncer; reusable for any slow mechanical input.
module switch_debounce
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_r;
  logic [CW-1:0] cnt_r;
  logic          level_r;

  // Synchronizer chain for the asynchronous raw input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], raw};
    end
  end

  // Accept a new level only after it has differed for the full run; any agreement restarts the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else if (sync_r[1] == level_r) begin
      cnt_r <= '0;
    end else if (cnt_r >= CNT_LAST) begin
      level_r <= sync_r[1];
      cnt_r   <= '0;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign level = level_r;

endmodule

// File: rtl/morse_mode_ctrl.sv
// Sequenced owner of ENCODE/DECODE mode: debounce, drain, flush, then hand over.
// Optional drain timeout and sticky timeout_flag are built when MODE_TIMEOUT_EN is defined.
module morse_mode_ctrl
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int FLUSH_CYCLES    = FLUSH_DEFAULT
`ifdef MODE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 50000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic switch,
`ifdef MODE_TIMEOUT_EN
  output logic timeout_flag,
`endif
  morse_mode_ctrl_if.master bus
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_FULL  = FW'(FLUSH_CYCLES);
  localparam logic [FW-1:0] FLUSH_FIRST = FW'(1);
`ifdef MODE_TIMEOUT_EN
  localparam int DW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(TIMEOUT_CYCLES - 1);

  logic [DW-1:0] dcnt_r;
  logic [DW-1:0] dcnt_s;
  logic          timeout_hit_s;
`endif

  ctrl_state_t   state_r;
  ctrl_state_t   next_state_s;
  mode_t         target_r;
  mode_t         target_s;
  logic [FW-1:0] fcnt_r;
  logic [FW-1:0] fcnt_s;
  logic          sw_db_s;
  logic          old_busy_s;
  logic          enc_en_s;
  logic          dec_en_s;
  logic          flush_s;
  logic          state1_s;
  logic          state2_s;
  logic          mode_busy_s;

  switch_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_switch_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (switch),
    .level (sw_db_s)
  );

  // Only the engine being drained is listened to; the idle one's busy is ignored.
  always_comb begin
    if (target_r == MODE_DEC) begin
      old_busy_s = bus.enc_busy;
    end else begin
      old_busy_s = bus.dec_busy;
    end
  end

  // State, latched target and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= INIT;
      target_r <= MODE_ENC;
      fcnt_r   <= '0;
`ifdef MODE_TIMEOUT_EN
      dcnt_r       <= '0;
      timeout_flag <= 1'b0;
`endif
    end else begin
      state_r  <= next_state_s;
      target_r <= target_s;
      fcnt_r   <= fcnt_s;
`ifdef MODE_TIMEOUT_EN
      dcnt_r       <= dcnt_s;
      timeout_flag <= timeout_flag | timeout_hit_s;
`endif
    end
  end

  // Next-state logic; target is latched once on DRAIN entry and held until the next RUN.
  always_comb begin
    next_state_s = state_r;
    target_s     = target_r;
    fcnt_s       = fcnt_r;
`ifdef MODE_TIMEOUT_EN
    dcnt_s        = '0;
    timeout_hit_s = 1'b0;
`endif
    case (state_r)
      INIT: begin
        if (fcnt_r == FLUSH_FULL) begin
          next_state_s = run_state(mode_t'(sw_db_s));
          fcnt_s       = '0;
        end else begin
          fcnt_s = fcnt_r + 1'b1;
        end
      end
      RUN_ENC: begin
        if (sw_db_s) begin
          next_state_s = DRAIN;
          target_s     = MODE_DEC;
        end else begin
          next_state_s = RUN_ENC;
        end
      end
      RUN_DEC: begin
        if (!sw_db_s) begin
          next_state_s = DRAIN;
          target_s     = MODE_ENC;
        end else begin
          next_state_s = RUN_DEC;
        end
      end
      DRAIN: begin
        if (!old_busy_s) begin
          next_state_s = FLUSH;
          fcnt_s       = FLUSH_FIRST;
`ifdef MODE_TIMEOUT_EN
        end else if (dcnt_r >= DRAIN_LAST) begin
          next_state_s  = FLUSH;
          fcnt_s        = FLUSH_FIRST;
          timeout_hit_s = 1'b1;
        end else begin
          dcnt_s = dcnt_r + 1'b1;
`else
        end else begin
          next_state_s = DRAIN;
`endif
        end
      end
      FLUSH: begin
        if (fcnt_r == FLUSH_FULL) begin
          next_state_s = run_state(target_r);
          fcnt_s       = '0;
        end else begin
          fcnt_s = fcnt_r + 1'b1;
        end
      end
      default: begin
        next_state_s = INIT;
        fcnt_s       = '0;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so the registered copies line up with it.
  always_comb begin
    enc_en_s    = 1'b0;
    dec_en_s    = 1'b0;
    flush_s     = 1'b0;
    state1_s    = 1'b0;
    state2_s    = 1'b0;
    mode_busy_s = 1'b1;
    case (next_state_s)
      INIT: begin
        flush_s = 1'b1;
      end
      RUN_ENC: begin
        enc_en_s    = 1'b1;
        state1_s    = 1'b1;
        mode_busy_s = 1'b0;
      end
      RUN_DEC: begin
        dec_en_s    = 1'b1;
        state2_s    = 1'b1;
        mode_busy_s = 1'b0;
      end
      DRAIN: begin
        if (target_s == MODE_DEC) begin
          enc_en_s = 1'b1;
          state1_s = 1'b1;
        end else begin
          dec_en_s = 1'b1;
          state2_s = 1'b1;
        end
      end
      FLUSH: begin
        flush_s = 1'b1;
      end
      default: begin
        mode_busy_s = 1'b1;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.enc_en    <= 1'b0;
      bus.dec_en    <= 1'b0;
      bus.flush     <= 1'b0;
      bus.state1    <= 1'b0;
      bus.state2    <= 1'b0;
      bus.mode_busy <= 1'b1;
    end else begin
      bus.enc_en    <= enc_en_s;
      bus.dec_en    <= dec_en_s;
      bus.flush     <= flush_s;
      bus.state1    <= state1_s;
      bus.state2    <= state2_s;
      bus.mode_busy <= mode_busy_s;
    end
  end

endmodule

// File: tb/tb_morse_mode_ctrl.sv
// Bench for morse_mode_ctrl: directed scenarios plus randomized run against a phase-level model.
module tb_morse_mode_ctrl;

  localparam int DEB = 8;
  localparam int FLC = 4;
  localparam int TMO = 16;

  localparam int P_START = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_FLUSH = 3;

  // {enc_en, dec_en, flush, state1, state2, mode_busy}
  localparam logic [5:0] V_RST   = 6'b000001;
  localparam logic [5:0] V_FLUSH = 6'b001001;
  localparam logic [5:0] V_ENC   = 6'b100100;
  localparam logic [5:0] V_DEC   = 6'b010010;
  localparam logic [5:0] V_DRE   = 6'b100101;

  logic clk = 1'b0;
  logic rst;
  logic switch;
`ifdef MODE_TIMEOUT_EN
  logic timeout_flag;
`endif

  int vectors = 0;
  int miscompares = 0;

  morse_mode_ctrl_if bus ();

  morse_mode_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .FLUSH_CYCLES    (FLC)
`ifdef MODE_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES  (TMO)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .switch       (switch),
`ifdef MODE_TIMEOUT_EN
    .timeout_flag (timeout_flag),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Phase-level reference: owner mode, pending target, countdowns.
  int m_s1, m_s2, m_db, m_cnt;
  int m_phase, m_owner, m_target, m_left, m_dcnt;
  bit m_flag;

  task automatic model_step();
    int old_busy;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_cnt = 0;
      m_phase = P_START; m_left = FLC + 1; m_owner = 0; m_target = 0; m_dcnt = 0;
      m_flag = 1'b0;
    end else begin
      case (m_phase)
        P_START: begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_phase = P_RUN; m_owner = m_db; end
        end
        P_RUN: begin
          if (m_db != m_owner) begin m_phase = P_DRAIN; m_target = m_db; m_dcnt = 0; end
        end
        P_DRAIN: begin
          old_busy = (m_owner == 1) ? int'(bus.dec_busy) : int'(bus.enc_busy);
          if (old_busy == 0) begin
            m_phase = P_FLUSH; m_left = FLC;
          end else begin
            m_dcnt = m_dcnt + 1;
`ifdef MODE_TIMEOUT_EN
            if (m_dcnt == TMO) begin m_phase = P_FLUSH; m_left = FLC; m_flag = 1'b1; end
`endif
          end
        end
        default: begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_phase = P_RUN; m_owner = m_target; end
        end
      endcase
      if (m_s2 != m_db) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == DEB) begin m_db = m_s2; m_cnt = 0; end
      end else begin
        m_cnt = 0;
      end
      m_s2 = m_s1;
      m_s1 = int'(switch);
    end
  endtask

  function automatic logic [5:0] model_vec();
    logic e, d, f;
    e = (m_phase == P_RUN || m_phase == P_DRAIN) && m_owner == 0;
    d = (m_phase == P_RUN || m_phase == P_DRAIN) && m_owner == 1;
    f = (m_phase == P_START && m_left <= FLC) || m_phase == P_FLUSH;
    return {e, d, f, e, d, (m_phase != P_RUN)};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {bus.enc_en, bus.dec_en, bus.flush, bus.state1, bus.state2, bus.mode_busy};
  endfunction

  // Advance one clock: the model consumes the inputs the DUT will sample, then wait to the next negedge.
  task automatic cycle();
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    rst = 1'b1; switch = 1'b0; bus.enc_busy = 1'b0; bus.dec_busy = 1'b0;
    cycle(); cycle();
    vectors++;
    if (dut_vec() !== V_RST) begin
      miscompares++;
      $display("FAIL reset_values got=%b exp=%b", dut_vec(), V_RST);
    end
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      exp = (i <= FLC) ? V_FLUSH : V_ENC;
      vectors++;
      if (dut_vec() !== exp) begin
        miscompares++;
        $display("FAIL init_flush cyc=%0d got=%b exp=%b", i, dut_vec(), exp);
      end
    end
  endtask

  task automatic test_switch_latency();
    logic [5:0] exp;
    switch = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      cycle();
      if (i <= 10) exp = V_ENC;
      else if (i == 11) exp = V_DRE;
      else if (i <= 15) exp = V_FLUSH;
      else exp = V_DEC;
      vectors++;
      if (dut_vec() !== exp) begin
        miscompares++;
        $display("FAIL latency cyc=%0d got=%b exp=%b", i, dut_vec(), exp);
      end
      vectors++;
      if ((bus.enc_en & bus.dec_en) !== 1'b0) begin
        miscompares++;
        $display("FAIL both_enabled cyc=%0d got=%b exp=0", i, bus.enc_en & bus.dec_en);
      end
    end
    switch = 1'b0;
    for (int i = 0; i < 30; i++) cycle();
    vectors++;
    if (dut_vec() !== V_ENC) begin
      miscompares++;
      $display("FAIL back_to_enc got=%b exp=%b", dut_vec(), V_ENC);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 52; i++) begin
      switch = (i < 40 && ((i / 3) % 2) == 0) ? 1'b1 : 1'b0;
      cycle();
      vectors++;
      if (dut_vec() !== V_ENC) begin
        miscompares++;
        $display("FAIL bounce cyc=%0d got=%b exp=%b", i, dut_vec(), V_ENC);
      end
    end
  endtask

  task automatic test_drain_busy();
    logic [5:0] exp;
    bus.enc_busy = 1'b1;
    switch = 1'b1;
    for (int i = 1; i <= 38; i++) begin
      bus.dec_busy = 1'($urandom_range(0, 1));
      if (i == 31) bus.enc_busy = 1'b0;
      cycle();
      if (i <= 10) exp = V_ENC;
      else if (i <= 30) exp = V_DRE;
      else if (i <= 34) exp = V_FLUSH;
      else exp = V_DEC;
      vectors++;
      if (dut_vec() !== exp) begin
        miscompares++;
        $display("FAIL drain_busy cyc=%0d got=%b exp=%b", i, dut_vec(), exp);
      end
    end
    bus.dec_busy = 1'b0;
    switch = 1'b0;
    for (int i = 0; i < 30; i++) cycle();
    vectors++;
    if (dut_vec() !== V_ENC) begin
      miscompares++;
      $display("FAIL drain_return got=%b exp=%b", dut_vec(), V_ENC);
    end
  endtask

  task automatic test_reset_mid_flush();
    logic [5:0] exp;
    switch = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      if (i == 14) rst = 1'b1;
      if (i == 15) rst = 1'b0;
      cycle();
      if (i <= 10) exp = V_ENC;
      else if (i == 11) exp = V_DRE;
      else if (i <= 13) exp = V_FLUSH;
      else if (i == 14) exp = V_RST;
      else if (i <= 18) exp = V_FLUSH;
      else exp = V_ENC;
      vectors++;
      if (dut_vec() !== exp) begin
        miscompares++;
        $display("FAIL reset_mid_flush cyc=%0d got=%b exp=%b", i, dut_vec(), exp);
      end
    end
    switch = 1'b0;
    for (int i = 0; i < 50; i++) cycle();
    vectors++;
    if (dut_vec() !== V_ENC) begin
      miscompares++;
      $display("FAIL reset_recover got=%b exp=%b", dut_vec(), V_ENC);
    end
  endtask

`ifdef MODE_TIMEOUT_EN
  task automatic test_timeout();
    logic [5:0] exp;
    bus.enc_busy = 1'b1;
    switch = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      cycle();
      if (i <= 10) exp = V_ENC;
      else if (i <= 26) exp = V_DRE;
      else if (i <= 30) exp = V_FLUSH;
      else exp = V_DEC;
      vectors++;
      if (dut_vec() !== exp) begin
        miscompares++;
        $display("FAIL timeout_seq cyc=%0d got=%b exp=%b", i, dut_vec(), exp);
      end
      vectors++;
      if (timeout_flag !== (i >= 27)) begin
        miscompares++;
        $display("FAIL timeout_flag cyc=%0d got=%b exp=%b", i, timeout_flag, (i >= 27));
      end
    end
    bus.enc_busy = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    vectors++;
    if (timeout_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_sticky got=%b exp=1", timeout_flag);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    vectors++;
    if (timeout_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear got=%b exp=0", timeout_flag);
    end
    switch = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
  endtask
`endif

  task automatic test_random();
    int hold = 0;
    for (int n = 0; n < 1500; n++) begin
      if (hold == 0) begin
        switch = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 24);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 3) == 0) bus.enc_busy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) bus.dec_busy = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 499) == 0);
      cycle();
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%b exp=%b", n, dut_vec(), model_vec());
      end
      vectors++;
      if ((bus.enc_en & bus.dec_en) !== 1'b0) begin
        miscompares++;
        $display("FAIL random_excl cyc=%0d got=%b exp=0", n, bus.enc_en & bus.dec_en);
      end
`ifdef MODE_TIMEOUT_EN
      vectors++;
      if (timeout_flag !== m_flag) begin
        miscompares++;
        $display("FAIL random_flag cyc=%0d got=%b exp=%b", n, timeout_flag, m_flag);
      end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    switch = 1'b0;
    bus.enc_busy = 1'b0;
    bus.dec_busy = 1'b0;
    test_reset();
    test_switch_latency();
    test_bounce();
    test_drain_busy();
    test_reset_mid_flush();
`ifdef MODE_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
